// File: rtl/wb_daq_write_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_daq_write_sequencer_pkg
// Description : Shared definitions for the DAQ write sequencer: FSM state
//               encodings, control register bit positions and the per-word
//               address stride.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package wb_daq_write_sequencer_pkg;

  // Bit position of the run-enable flag inside control_reg.
  localparam int DAQ_CTRL_ENABLE = 0;

  // Byte stride between consecutive 32-bit word writes.
  localparam int DAQ_ADDR_INCR = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_LATCH     = 3'd2,
    ST_ISSUE     = 3'd3,
    ST_WAIT_ACT  = 3'd4,
    ST_WAIT_DONE = 3'd5,
    ST_COMPLETE  = 3'd6
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/wb_daq_write_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_daq_write_sequencer_if
// Description : Request port between the write sequencer and the Wishbone
//               bus master.
// Signals     : start     - one-cycle request pulse
//               address   - byte address of the write
//               selection - byte lane select
//               write     - write/read select (always write here)
//               data_wr   - write data
//               active    - bus master busy flag (fed back to requester)
// Modports    : master - request generator side (sequencer)
//               slave  - bus master side
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_daq_write_sequencer_if #(
  parameter int dw = 32,
  parameter int aw = 32
);
  logic          start;
  logic [aw-1:0] address;
  logic [3:0]    selection;
  logic          write;
  logic [dw-1:0] data_wr;
  logic          active;

  modport master (
    output start, address, selection, write, data_wr,
    input  active
  );

  modport slave (
    input  start, address, selection, write, data_wr,
    output active
  );
endinterface
`default_nettype wire

// File: rtl/wb_daq_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : wb_daq_write_sequencer
// Description : Drains samples from the DAQ sample FIFO and issues one
//               single-word Wishbone write per sample to incrementing word
//               addresses, starting at base_address, until sample_count
//               words have been written.
// Ports       : wb_clk, wb_rst_n  - clock, async active-low reset
//               control_reg       - bit DAQ_CTRL_ENABLE starts/aborts runs
//               base_address      - first byte address (latched at start)
//               sample_count      - words per run (latched at start)
//               fifo_empty/data   - sample FIFO status and read data
//               fifo_rd_en        - FIFO pop strobe
//               busy/done         - run in progress / run-complete pulse
//               words_written     - words completed in current/last run
//               bus               - request port to the bus master
// Revision    : 1.0 - initial release
// ============================================================================
module wb_daq_write_sequencer
  import wb_daq_write_sequencer_pkg::*;
#(
  parameter int dw = 32,
  parameter int aw = 32,
  parameter int CW = 16
) (
  input  logic                 wb_clk,
  input  logic                 wb_rst_n,
  input  logic [dw-1:0]        control_reg,
  input  logic [aw-1:0]        base_address,
  input  logic [CW-1:0]        sample_count,
  input  logic                 fifo_empty,
  input  logic [dw-1:0]        fifo_data,
  output logic                 fifo_rd_en,
  output logic                 busy,
  output logic                 done,
  output logic [CW-1:0]        words_written,
  wb_daq_write_sequencer_if.master bus
);

  seq_state_t    r_state;
  logic          r_enable_prev;
  logic [aw-1:0] r_address;
  logic [dw-1:0] r_data;
  logic [CW-1:0] r_target;
  logic          r_start;

  logic          w_enable;
  logic [CW-1:0] w_next_count;
  logic          w_unused_ctrl;

  assign w_enable      = control_reg[DAQ_CTRL_ENABLE];
  assign w_next_count  = words_written + CW'(1);
  // Only the enable bit is defined; the rest of control_reg is ignored.
  assign w_unused_ctrl = ^control_reg;

  assign bus.start     = r_start;
  assign bus.address   = r_address;
  assign bus.data_wr   = r_data;
  assign bus.selection = 4'hF;
  assign bus.write     = 1'b1;

  // The FIFO pop is registered one step ahead: whenever the FSM enters (or
  // sits in) FETCH, fifo_rd_en is loaded from the current fifo_empty, so the
  // strobe is high during the FETCH cycle itself. The sequencer is the only
  // consumer, so a FIFO seen non-empty stays non-empty until it pops. Once
  // the strobe has fired the word is committed and finished even if enable
  // falls, so a popped sample is never dropped.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_state       <= ST_IDLE;
      r_enable_prev <= 1'b0;
      r_address     <= '0;
      r_data        <= '0;
      r_target      <= '0;
      r_start       <= 1'b0;
      fifo_rd_en    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      words_written <= '0;
    end else begin
      r_enable_prev <= w_enable;

      case (r_state)
        ST_IDLE: begin
          if (w_enable && !r_enable_prev) begin
            r_address     <= base_address;
            r_target      <= sample_count;
            words_written <= '0;
            busy          <= 1'b1;
            if (sample_count == '0) begin
              done    <= 1'b1;
              r_state <= ST_COMPLETE;
            end else begin
              fifo_rd_en <= !fifo_empty;
              r_state    <= ST_FETCH;
            end
          end
        end

        ST_FETCH: begin
          if (fifo_rd_en) begin
            fifo_rd_en <= 1'b0;
            r_state    <= ST_LATCH;
          end else if (!w_enable) begin
            busy    <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            fifo_rd_en <= !fifo_empty;
          end
        end

        ST_LATCH: begin
          r_data  <= fifo_data;
          r_start <= 1'b1;
          r_state <= ST_ISSUE;
        end

        ST_ISSUE: begin
          r_start <= 1'b0;
          r_state <= ST_WAIT_ACT;
        end

        ST_WAIT_ACT: begin
          if (bus.active) begin
            r_state <= ST_WAIT_DONE;
          end
        end

        ST_WAIT_DONE: begin
          if (!bus.active) begin
            words_written <= w_next_count;
            r_address     <= r_address + aw'(DAQ_ADDR_INCR);
            if (w_next_count == r_target) begin
              done    <= 1'b1;
              r_state <= ST_COMPLETE;
            end else if (!w_enable) begin
              busy    <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              fifo_rd_en <= !fifo_empty;
              r_state    <= ST_FETCH;
            end
          end
        end

        ST_COMPLETE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_start    <= 1'b0;
          fifo_rd_en <= 1'b0;
          done       <= 1'b0;
          busy       <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
